// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding, default sizing and ASCII reply bytes.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_LOCK_TIMEOUT = 1023;

  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: first eligible valid requester at or
// above i_rr_ptr wins, otherwise the first one below it (wrap-around).
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  input  logic [NUM_REQ-1:0]         i_elig,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_cand;

  assign w_cand = i_req_valid & i_elig;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && w_cand[k] && (k >= int'(i_rr_ptr))) begin
        o_any      = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && w_cand[k] && (k < int'(i_rr_ptr))) begin
        o_any      = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart_fifo TX write port among byte producers.
// Optional message locking is built when UART_TX_ARB_LOCK_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                       Pclk,
  input  logic                       RESET_N,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_byte,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_byte,
  output logic                       transmit,
  input  logic                       tx_fifo_full,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       lock_timeout,
  output arb_state_e                 dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a byte moves when req_valid[i] & req_ready[i]; req_ready is one-hot,
  // only raised in IDLE with room in the FIFO, and must not feed back into req_valid.

  arb_state_e         r_state;
  logic [7:0]         r_tx_byte;
  logic               r_transmit;
  logic [IW-1:0]      r_grant_id;
  logic [IW-1:0]      r_rr_ptr;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic               w_can_accept;
  logic               w_xfer;
  logic [7:0]         w_sel_byte;
  logic               w_lock_held;
  logic               w_ptr_upd;
  logic [IW-1:0]      w_ptr_src;
  logic [IW-1:0]      w_ptr_next;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .i_elig      (w_elig),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any       (w_any)
  );

  assign w_can_accept = RESET_N && (r_state == ST_IDLE) && !tx_fifo_full;
  assign w_xfer       = w_can_accept && w_any;
  assign req_ready    = w_can_accept ? w_grant : '0;
  assign w_sel_byte   = req_byte[{w_idx, 3'b000} +: 8];
  assign w_ptr_next   = (w_ptr_src == IW'(NUM_REQ - 1)) ? '0 : w_ptr_src + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic          r_lock_held;
  logic [IW-1:0] r_owner;
  logic [CW-1:0] r_to_cnt;
  logic          w_sel_last;
  logic          w_owner_idle;
  logic          w_timeout;

  assign w_sel_last   = req_last[w_idx];
  assign w_lock_held  = r_lock_held;
  assign w_elig       = r_lock_held ? (ONE_HOT0 << r_owner) : '1;
  assign w_owner_idle = r_lock_held && (r_state == ST_IDLE) && !req_valid[r_owner];
  // A waiting owner that raises valid on the last count still wins, since it is then not idle.
  assign w_timeout    = RESET_N && w_owner_idle && (r_to_cnt == CW'(LOCK_TIMEOUT - 1));
  assign lock_timeout = w_timeout;
  assign w_ptr_upd    = (w_xfer && (!r_lock_held || w_sel_last)) || w_timeout;
  assign w_ptr_src    = w_timeout ? r_owner : w_idx;

  always_ff @(posedge Pclk) begin
    if (!RESET_N) begin
      r_lock_held <= 1'b0;
      r_owner     <= '0;
      r_to_cnt    <= '0;
    end else if (w_xfer) begin
      r_to_cnt    <= '0;
      r_lock_held <= !w_sel_last;
      if (!w_sel_last) r_owner <= w_idx;
    end else if (w_timeout) begin
      r_lock_held <= 1'b0;
      r_to_cnt    <= '0;
    end else if (w_owner_idle) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else if (!r_lock_held) begin
      r_to_cnt <= '0;
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (^req_last) ^ (LOCK_TIMEOUT > 0);
  assign w_lock_held  = 1'b0;
  assign w_elig       = '1;
  assign lock_timeout = 1'b0;
  assign w_ptr_upd    = w_xfer;
  assign w_ptr_src    = w_idx;
`endif

  always_ff @(posedge Pclk) begin
    if (!RESET_N) begin
      r_state    <= ST_IDLE;
      r_tx_byte  <= 8'h00;
      r_transmit <= 1'b0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_state    <= ST_SEND;
            r_tx_byte  <= w_sel_byte;
            r_transmit <= 1'b1;
            r_grant_id <= w_idx;
          end
        end
        ST_SEND: begin
          r_state    <= ST_GAP;
          r_transmit <= 1'b0;
        end
        ST_GAP: r_state <= ST_IDLE;
        default: begin
          r_state    <= ST_IDLE;
          r_transmit <= 1'b0;
        end
      endcase
      if (w_ptr_upd) r_rr_ptr <= w_ptr_next;
    end
  end

  assign tx_byte   = r_tx_byte;
  assign transmit  = r_transmit;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE) || w_lock_held;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; lock scenarios run when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ = 4;

  logic             Pclk;
  logic             RESET_N;
  logic [NREQ-1:0]  req_valid;
  logic [8*NREQ-1:0] req_byte;
  logic [NREQ-1:0]  req_last;
  logic [NREQ-1:0]  req_ready;
  logic [7:0]       tx_byte;
  logic             transmit;
  logic             tx_fifo_full;
  logic [1:0]       grant_id;
  logic             busy;
  logic             lock_timeout;
  arb_state_e       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .LOCK_TIMEOUT(8)) dut (
    .Pclk         (Pclk),
    .RESET_N      (RESET_N),
    .req_valid    (req_valid),
    .req_byte     (req_byte),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_byte      (tx_byte),
    .transmit     (transmit),
    .tx_fifo_full (tx_fifo_full),
    .grant_id     (grant_id),
    .busy         (busy),
    .lock_timeout (lock_timeout),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc_begin();
    @(posedge Pclk);
    #1;
  endtask

  task automatic mid();
    @(negedge Pclk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] b, input logic l);
    req_valid[i]        = v;
    req_byte[8*i +: 8]  = b;
    req_last[i]         = l;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
  endtask

  // scoreboard: every transmit strobe must match the next expected {grant_id, byte}
  always @(negedge Pclk) begin
    if (transmit === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("tx_unexpected", {22'd0, grant_id, tx_byte}, 32'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("tx_byte_gid", {22'd0, grant_id, tx_byte}, {22'd0, mon_exp});
      end
    end
  end

  initial begin
    logic [7:0] msg [3];
    int idx;
    msg[0] = ASCII_S;
    msg[1] = ASCII_C;
    msg[2] = ASCII_EQ;

    RESET_N      = 1'b0;
    tx_fifo_full = 1'b0;
    clear_reqs();
    repeat (3) cyc_begin();
    mid();
    check_val("rst_ready", req_ready, 0);
    check_val("rst_tx_byte", tx_byte, 0);
    check_val("rst_transmit", transmit, 0);
    check_val("rst_grant", grant_id, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_lock_to", lock_timeout, 0);
    check_val("rst_state", dbg_state, ST_IDLE);
    cyc_begin();
    RESET_N = 1'b1;

    // Round robin between requesters 0 and 2, one byte per 3 cycles
    set_req(0, 1'b1, ASCII_W, 1'b1);
    set_req(2, 1'b1, ASCII_S, 1'b1);
    exp_q.push_back({2'd0, ASCII_W});
    exp_q.push_back({2'd2, ASCII_S});
    exp_q.push_back({2'd0, ASCII_W});
    exp_q.push_back({2'd2, ASCII_S});
    for (int c = 0; c < 12; c++) begin
      mid();
      check_val("rr_transmit", transmit, (c % 3 == 1) ? 1 : 0);
      if (c % 3 == 0)
        check_val("rr_ready", req_ready, ((c / 3) % 2 == 0) ? 4'b0001 : 4'b0100);
      else
        check_val("rr_ready_off", req_ready, 0);
      if (c == 2) check_val("rr_busy_gap", busy, 1);
      cyc_begin();
    end
    clear_reqs();

    // FIFO full holds requester 1 off for 10 cycles
    tx_fifo_full = 1'b1;
    set_req(1, 1'b1, ASCII_C, 1'b1);
    exp_q.push_back({2'd1, ASCII_C});
    for (int c = 0; c < 10; c++) begin
      mid();
      check_val("full_ready", req_ready, 0);
      check_val("full_transmit", transmit, 0);
      cyc_begin();
    end
    tx_fifo_full = 1'b0;
    mid();
    check_val("full_release_ready", req_ready, 4'b0010);
    check_val("full_release_tx", transmit, 0);
    cyc_begin();
    clear_reqs();
    tx_fifo_full = 1'b1;
    mid();
    check_val("full_strobe", transmit, 1);
    cyc_begin();
    tx_fifo_full = 1'b0;
    cyc_begin();

    // Reset in the SEND cycle; pointer returns to 0 so requester 0 wins first
    set_req(0, 1'b1, ASCII_W, 1'b1);
    exp_q.push_back({2'd0, ASCII_W});
    mid();
    check_val("rst_pre_ready", req_ready, 4'b0001);
    cyc_begin();
    RESET_N = 1'b0;
    set_req(2, 1'b1, ASCII_S, 1'b1);
    mid();
    check_val("rst_send_state", dbg_state, ST_SEND);
    check_val("rst_send_ready", req_ready, 0);
    cyc_begin();
    mid();
    check_val("rst_mid_transmit", transmit, 0);
    check_val("rst_mid_tx_byte", tx_byte, 0);
    check_val("rst_mid_grant", grant_id, 0);
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_lock_to", lock_timeout, 0);
    check_val("rst_mid_ready", req_ready, 0);
    cyc_begin();
    RESET_N = 1'b1;
    exp_q.push_back({2'd0, ASCII_W});
    mid();
    check_val("rst_first_winner", req_ready, 4'b0001);
    cyc_begin();
    clear_reqs();
    cyc_begin();
    cyc_begin();

`ifdef UART_TX_ARB_LOCK_EN
    // Requester 3 message "SC=" is not interleaved with requester 0
    idx = 0;
    exp_q.push_back({2'd3, ASCII_S});
    exp_q.push_back({2'd3, ASCII_C});
    exp_q.push_back({2'd3, ASCII_EQ});
    exp_q.push_back({2'd0, ASCII_W});
    for (int c = 0; c < 12; c++) begin
      set_req(3, idx < 3, msg[(idx < 3) ? idx : 2], idx == 2);
      set_req(0, c < 10, ASCII_W, 1'b1);
      mid();
      if ((c % 3 == 0) && (c < 9)) check_val("lock_ready_owner", req_ready, 4'b1000);
      if (c == 3) check_val("lock_busy_held", busy, 1);
      if (c == 9) begin
        check_val("lock_ready_after", req_ready, 4'b0001);
        check_val("lock_busy_free", busy, 0);
      end
      if (req_ready[3]) idx++;
      cyc_begin();
    end
    clear_reqs();

    // Owner 1 stalls; lock is forced off in the 8th idle cycle
    set_req(1, 1'b1, ASCII_A, 1'b0);
    exp_q.push_back({2'd1, ASCII_A});
    exp_q.push_back({2'd2, ASCII_S});
    for (int c = 0; c < 13; c++) begin
      if (c >= 1) begin
        set_req(1, 1'b0, ASCII_A, 1'b0);
        set_req(2, 1'b1, ASCII_S, 1'b1);
        set_req(0, 1'b1, ASCII_W, 1'b1);
      end
      if (c >= 12) clear_reqs();
      mid();
      if (c == 0) check_val("to_first_ready", req_ready, 4'b0010);
      if ((c >= 3) && (c <= 10)) check_val("to_ready_blocked", req_ready, 0);
      if ((c >= 3) && (c <= 11)) check_val("to_pulse", lock_timeout, (c == 10) ? 1 : 0);
      if (c == 5) check_val("to_busy_held", busy, 1);
      if (c == 11) check_val("to_next_grant", req_ready, 4'b0100);
      cyc_begin();
    end
    cyc_begin();
`else
    // Without locking, req_last=0 does not hold the grant
    set_req(3, 1'b1, ASCII_S, 1'b0);
    set_req(0, 1'b1, ASCII_W, 1'b0);
    exp_q.push_back({2'd3, ASCII_S});
    exp_q.push_back({2'd0, ASCII_W});
    exp_q.push_back({2'd3, ASCII_S});
    for (int c = 0; c < 9; c++) begin
      mid();
      if (c % 3 == 0) check_val("nolock_ready", req_ready, (c == 3) ? 4'b0001 : 4'b1000);
      check_val("nolock_busy", busy, (c % 3 != 0) ? 1 : 0);
      check_val("nolock_lock_to", lock_timeout, 0);
      cyc_begin();
      if (c == 6) clear_reqs();
    end
`endif

    repeat (3) cyc_begin();
    check_val("tx_missing", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
